button_event_arbiter: RTL and testbench
=======================================

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter NUM_BUTTONS, default 4, number of debounced button inputs (2..8).
REQ-002 Parameter LONG_PRESS_CYCLES, default 50000000, hold time in clk cycles for a long-press event (1 s at 50 MHz).
REQ-003 Parameter FIFO_DEPTH, default 4, event queue entries (power of two, >=2).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_db  input  NUM_BUTTONS  debounced button levels, 1 = pressed, already synchronous to clk.
REQ-007 evt_valid  output  1  queue head holds an event.
REQ-008 evt_ready  input  1  consumer accepts head when evt_valid is also 1.
REQ-009 evt_id  output  3  button index of head event.
REQ-010 evt_type  output  2  head event type: 00 PRESS, 01 RELEASE, 10 LONG; 11 never emitted.
REQ-011 overflow  output  1  sticky flag: an event was dropped.
REQ-012 overflow_clr  input  1  clears overflow for one cycle.

Function
REQ-013 Per button, prev register holds the last sampled btn_db bit; rise = btn_db & ~prev, fall = ~btn_db & prev.
REQ-014 Per-button FSM states IDLE, PRESSED, HELD; IDLE -rise-> PRESSED (emit PRESS, hold counter = 0); PRESSED -fall-> IDLE (emit RELEASE); PRESSED -counter == LONG_PRESS_CYCLES-1-> HELD (emit LONG); HELD -fall-> IDLE (emit RELEASE).
REQ-015 Hold counter 32 bits, increments only in PRESSED, saturates by leaving PRESSED; never wraps.
REQ-016 An emitted event is written into the button's 1-entry pending slot (valid + 2-bit type) on the same edge the edge/count is detected.
REQ-017 Arbiter: each cycle at most one pending slot granted, fixed priority, lowest index wins, grant only when FIFO not full.
REQ-018 Granted slot is pushed into the FIFO and cleared on the same edge; if that button emits a new event on that edge, the slot takes the new event, no overflow.
REQ-019 Event emitted while the button's slot is valid and not granted that cycle: new event dropped, slot unchanged, overflow set.
REQ-020 FIFO full: no grant; pending slots hold (backpressure), no drop until REQ-019 applies.
REQ-021 Push allowed only when registered count < FIFO_DEPTH; a pop in the same cycle does not enable a push into a full FIFO.
REQ-022 Pop on evt_valid & evt_ready; evt_id/evt_type stable while evt_valid & ~evt_ready.
REQ-023 Latency: btn_db change first sampled at edge k, empty FIFO, no higher-priority pending -> evt_valid = 1 after edge k+1.
REQ-024 Events of one button leave the FIFO in emission order.
REQ-025 overflow_clr and a same-cycle drop: set wins.

Reset
REQ-026 While reset = 1 at an edge: all FSMs IDLE, prev = 0, counters = 0, pending slots invalid, FIFO empty, overflow = 0.
REQ-027 After reset: evt_valid = 0, evt_id = 0, evt_type = 00, overflow = 0.
REQ-028 Button held through reset release produces a PRESS on the first post-reset edge (prev = 0).
REQ-029 Reset mid-operation discards all queued and pending events without output.

Structure
REQ-030 Package button_evt_pkg holds evt_type encoding constants (PRESS, RELEASE, LONG), FSM state encoding, and event record width.
REQ-031 FIFO is sub-module button_event_fifo (synchronous, registered count, same reset); FSM, pending slots and arbiter live in the top.

Verification
REQ-032 btn_db[0] 0->1 at edge 10, evt_ready = 1 -> evt_valid at edge 11 with id 0, type 00; release later -> type 01.
REQ-033 LONG_PRESS_CYCLES = 8, hold btn 2 for 20 cycles -> sequence PRESS, LONG (8 cycles after PRESS emission), RELEASE, all id 2.
REQ-034 btn_db 0000->1111 in one cycle, evt_ready = 1 -> PRESS ids 0,1,2,3 in consecutive cycles.
REQ-035 evt_ready = 0, FIFO_DEPTH = 4, 6 distinct press/release events -> evt_valid held, head stable, 4 queued, 2 pending, overflow 0; evt_ready = 1 -> all 6 delivered in order.
REQ-036 evt_ready = 0, FIFO full, button 1 press then release with slot still pending -> overflow = 1; overflow_clr pulse -> 0.
REQ-037 Reset asserted with 3 queued events and button held -> evt_valid 0 during reset; after release exactly one PRESS for held button.

Source files
------------

// File: rtl/button_evt_pkg.sv
// rtl/button_evt_pkg.sv - shared event encodings, FSM states and event record layout
package button_evt_pkg;

   // Event type codes carried on evt_type; 2'b11 is never produced
   localparam logic [1:0] EVT_PRESS   = 2'b00;
   localparam logic [1:0] EVT_RELEASE = 2'b01;
   localparam logic [1:0] EVT_LONG    = 2'b10;

   localparam int EVT_ID_W   = 3;
   localparam int EVT_TYPE_W = 2;
   localparam int EVT_REC_W  = EVT_ID_W + EVT_TYPE_W;

   // Per-button press tracking
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PRESSED = 2'b01,
      ST_HELD    = 2'b10
   } btn_state_e;

   // One queued event: which button and what happened
   typedef struct packed {
      logic [EVT_ID_W-1:0]   id;
      logic [EVT_TYPE_W-1:0] etype;
   } evt_rec_t;

endpackage

// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - event output handshake between arbiter and consumer
interface button_event_arbiter_if;
   import button_evt_pkg::*;

   logic                  evt_valid;
   logic                  evt_ready;
   logic [EVT_ID_W-1:0]   evt_id;
   logic [EVT_TYPE_W-1:0] evt_type;

   // Producer side: the arbiter
   modport master (output evt_valid, output evt_id, output evt_type, input evt_ready);
   // Consumer side
   modport slave  (input evt_valid, input evt_id, input evt_type, output evt_ready);
endinterface

// File: rtl/button_event_fifo.sv
// rtl/button_event_fifo.sv - synchronous event queue with registered occupancy count
module button_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Fullness comes from the registered count only, so a same-cycle pop never frees a slot early
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   // Head reads as zero when empty so the output bus is clean after reset
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer and count next state; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - per-button press/release/long detection with priority event queue
module button_event_arbiter
   import button_evt_pkg::*;
#(
   parameter int NUM_BUTTONS       = 4,
   parameter int LONG_PRESS_CYCLES = 50000000,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] btn_db,
   button_event_arbiter_if.master evt_if,
   output logic                   overflow,
   input  logic                   overflow_clr
);
   localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_CYCLES - 1);

   btn_state_e             state_q [NUM_BUTTONS];
   btn_state_e             state_d [NUM_BUTTONS];
   logic [31:0]            cnt_q [NUM_BUTTONS];
   logic [31:0]            cnt_d [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] prev_q;
   logic [NUM_BUTTONS-1:0] rise;
   logic [NUM_BUTTONS-1:0] fall;
   logic [NUM_BUTTONS-1:0] emit;
   logic [1:0]             emit_type [NUM_BUTTONS];

   logic [NUM_BUTTONS-1:0] slot_valid_q, slot_valid_d;
   logic [1:0]             slot_type_q [NUM_BUTTONS];
   logic [1:0]             slot_type_d [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] grant;
   logic [NUM_BUTTONS-1:0] drop;
   logic                   arb_found;
   evt_rec_t               push_rec;
   evt_rec_t               head_rec;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   overflow_q, overflow_d;

   assign rise = btn_db & ~prev_q;
   assign fall = ~btn_db & prev_q;

   // Press-tracking FSM per button; the counter only advances while PRESSED, so it cannot wrap
   always_comb begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         state_d[i]   = state_q[i];
         cnt_d[i]     = cnt_q[i];
         emit[i]      = 1'b0;
         emit_type[i] = EVT_PRESS;
         case (state_q[i])
            ST_IDLE: begin
               if (rise[i]) begin
                  state_d[i]   = ST_PRESSED;
                  cnt_d[i]     = '0;
                  emit[i]      = 1'b1;
                  emit_type[i] = EVT_PRESS;
               end
            end
            ST_PRESSED: begin
               if (fall[i]) begin
                  state_d[i]   = ST_IDLE;
                  emit[i]      = 1'b1;
                  emit_type[i] = EVT_RELEASE;
               end else if (cnt_q[i] == LONG_LAST) begin
                  state_d[i]   = ST_HELD;
                  emit[i]      = 1'b1;
                  emit_type[i] = EVT_LONG;
               end else begin
                  cnt_d[i] = cnt_q[i] + 32'd1;
               end
            end
            ST_HELD: begin
               if (fall[i]) begin
                  state_d[i]   = ST_IDLE;
                  emit[i]      = 1'b1;
                  emit_type[i] = EVT_RELEASE;
               end
            end
            default: state_d[i] = ST_IDLE;
         endcase
      end
   end

   // Fixed-priority grant of one pending slot per cycle, lowest index first, only with queue space
   always_comb begin
      grant     = '0;
      arb_found = 1'b0;
      push_rec  = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (slot_valid_q[i] && !arb_found && !fifo_full) begin
            grant[i]       = 1'b1;
            arb_found      = 1'b1;
            push_rec.id    = EVT_ID_W'(i);
            push_rec.etype = slot_type_q[i];
         end
      end
   end

   // Pending slot update: a granted slot can refill on the same edge, an occupied one drops new events
   always_comb begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         slot_valid_d[i] = slot_valid_q[i];
         slot_type_d[i]  = slot_type_q[i];
         drop[i]         = 1'b0;
         if (grant[i]) begin
            slot_valid_d[i] = emit[i];
            slot_type_d[i]  = emit_type[i];
         end else if (emit[i]) begin
            if (slot_valid_q[i]) begin
               drop[i] = 1'b1;
            end else begin
               slot_valid_d[i] = 1'b1;
               slot_type_d[i]  = emit_type[i];
            end
         end
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (|drop)             overflow_d = 1'b1;
      else if (overflow_clr) overflow_d = 1'b0;
      else                   overflow_d = overflow_q;
   end

   // State registers; reset clears history so a held button re-reports PRESS afterwards
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q       <= '0;
         slot_valid_q <= '0;
         overflow_q   <= 1'b0;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_q[i]     <= ST_IDLE;
            cnt_q[i]       <= '0;
            slot_type_q[i] <= EVT_PRESS;
         end
      end else begin
         prev_q       <= btn_db;
         slot_valid_q <= slot_valid_d;
         overflow_q   <= overflow_d;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_q[i]     <= state_d[i];
            cnt_q[i]       <= cnt_d[i];
            slot_type_q[i] <= slot_type_d[i];
         end
      end
   end

   button_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_REC_W)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (|grant),
      .push_data_i (push_rec),
      .pop_i       (evt_if.evt_ready),
      .head_o      (head_rec),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign evt_if.evt_valid = ~fifo_empty;
   assign evt_if.evt_id    = head_rec.id;
   assign evt_if.evt_type  = head_rec.etype;
   assign overflow         = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - directed self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_db;
   logic       overflow;
   logic       overflow_clr;
   int         cyc = 0;
   int         passed = 0;
   int         total = 0;
   int         k;

   typedef struct {
      int         c;
      logic [2:0] id;
      logic [1:0] t;
   } rec_t;
   rec_t mon_q [$];

   button_event_arbiter_if ifc ();

   button_event_arbiter #(
      .NUM_BUTTONS       (4),
      .LONG_PRESS_CYCLES (8),
      .FIFO_DEPTH        (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_db       (btn_db),
      .evt_if       (ifc),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted handshake with the cycle in which it was presented
   always @(posedge clk) begin
      if (!reset && ifc.evt_valid && ifc.evt_ready)
         mon_q.push_back('{cyc, ifc.evt_id, ifc.evt_type});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_events(input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (mon_q.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(tag, 32'(mon_q.size() >= n), 32'd1);
   endtask

   task automatic chk_evt(input int idx, input logic [2:0] id, input logic [1:0] t, input string tag);
      logic [2:0] oid;
      logic [1:0] ot;
      oid = 3'bxxx;
      ot  = 2'bxx;
      if (idx < mon_q.size()) begin
         oid = mon_q[idx].id;
         ot  = mon_q[idx].t;
      end
      chk({tag, "_id"}, 32'(oid), 32'(id));
      chk({tag, "_type"}, 32'(ot), 32'(t));
   endtask

   initial begin
      reset        = 1'b1;
      btn_db       = 4'b0000;
      overflow_clr = 1'b0;
      ifc.evt_ready = 1'b1;
      step(3);
      chk("rst_valid", 32'(ifc.evt_valid), 32'd0);
      chk("rst_id", 32'(ifc.evt_id), 32'd0);
      chk("rst_type", 32'(ifc.evt_type), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;
      step(2);

      // Single press/release on button 0 with latency check
      btn_db = 4'b0001;
      k = cyc + 1;
      step(1);
      chk("lat_edge_k", 32'(ifc.evt_valid), 32'd0);
      step(1);
      chk("lat_valid", 32'(ifc.evt_valid), 32'd1);
      chk("lat_id", 32'(ifc.evt_id), 32'd0);
      chk("lat_type", 32'(ifc.evt_type), 32'd0);
      btn_db = 4'b0000;
      step(2);
      chk("rel_valid", 32'(ifc.evt_valid), 32'd1);
      chk("rel_id", 32'(ifc.evt_id), 32'd0);
      chk("rel_type", 32'(ifc.evt_type), 32'd1);
      step(2);
      chk("rel_drained", 32'(ifc.evt_valid), 32'd0);
      mon_q.delete();

      // All four pressed together: priority order in consecutive cycles
      btn_db = 4'b1111;
      k = cyc + 1;
      wait_events(4, 20, "all_press_wait");
      for (int i = 0; i < 4; i++) begin
         chk_evt(i, 3'(i), 2'b00, "all_press");
         if (i < mon_q.size()) chk("all_press_cyc", 32'(mon_q[i].c), 32'(k + 1 + i));
      end
      mon_q.delete();
      btn_db = 4'b0000;
      wait_events(4, 20, "all_rel_wait");
      for (int i = 0; i < 4; i++) chk_evt(i, 3'(i), 2'b01, "all_rel");
      step(3);
      mon_q.delete();

      // Long press on button 2
      btn_db = 4'b0100;
      step(20);
      btn_db = 4'b0000;
      wait_events(3, 40, "long_wait");
      chk_evt(0, 3'd2, 2'b00, "long_p");
      chk_evt(1, 3'd2, 2'b10, "long_l");
      chk_evt(2, 3'd2, 2'b01, "long_r");
      if (mon_q.size() >= 2) chk("long_delay", 32'(mon_q[1].c - mon_q[0].c), 32'd8);
      step(3);
      mon_q.delete();

      // Backpressure: 4 queued, 2 pending, no overflow, then ordered drain
      ifc.evt_ready = 1'b0;
      btn_db = 4'b0111;
      step(4);
      btn_db = 4'b0000;
      step(3);
      chk("bp_valid", 32'(ifc.evt_valid), 32'd1);
      chk("bp_id", 32'(ifc.evt_id), 32'd0);
      chk("bp_type", 32'(ifc.evt_type), 32'd0);
      chk("bp_ovf", 32'(overflow), 32'd0);
      chk("bp_count", 32'(dut.u_fifo.count_q), 32'd4);
      chk("bp_pending", 32'(dut.slot_valid_q), 32'b0110);
      step(2);
      chk("bp_stable_id", 32'(ifc.evt_id), 32'd0);
      chk("bp_stable_type", 32'(ifc.evt_type), 32'd0);
      chk("bp_stable_valid", 32'(ifc.evt_valid), 32'd1);
      ifc.evt_ready = 1'b1;
      wait_events(6, 40, "bp_wait");
      chk_evt(0, 3'd0, 2'b00, "bp0");
      chk_evt(1, 3'd1, 2'b00, "bp1");
      chk_evt(2, 3'd2, 2'b00, "bp2");
      chk_evt(3, 3'd0, 2'b01, "bp3");
      chk_evt(4, 3'd1, 2'b01, "bp4");
      chk_evt(5, 3'd2, 2'b01, "bp5");
      step(3);
      chk("bp_drained", 32'(ifc.evt_valid), 32'd0);
      mon_q.delete();

      // Overflow: full queue, button 1 press pending, release dropped
      ifc.evt_ready = 1'b0;
      btn_db = 4'b0101;
      step(3);
      btn_db = 4'b0000;
      step(3);
      btn_db = 4'b0010;
      step(1);
      chk("ovf_before", 32'(overflow), 32'd0);
      chk("ovf_pending", 32'(dut.slot_valid_q), 32'b0010);
      btn_db = 4'b0000;
      step(1);
      chk("ovf_set", 32'(overflow), 32'd1);
      step(2);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      step(1);
      overflow_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);
      ifc.evt_ready = 1'b1;
      wait_events(5, 40, "ovf_wait");
      chk_evt(0, 3'd0, 2'b00, "ovf0");
      chk_evt(1, 3'd2, 2'b00, "ovf1");
      chk_evt(2, 3'd0, 2'b01, "ovf2");
      chk_evt(3, 3'd2, 2'b01, "ovf3");
      chk_evt(4, 3'd1, 2'b00, "ovf4");
      step(3);
      chk("ovf_drained", 32'(ifc.evt_valid), 32'd0);
      mon_q.delete();

      // Reset mid-operation with button 1 held through it
      ifc.evt_ready = 1'b0;
      btn_db = 4'b0111;
      step(5);
      chk("mid_valid", 32'(ifc.evt_valid), 32'd1);
      chk("mid_count", 32'(dut.u_fifo.count_q), 32'd3);
      btn_db = 4'b0010;
      reset  = 1'b1;
      step(1);
      chk("mrst_valid", 32'(ifc.evt_valid), 32'd0);
      chk("mrst_id", 32'(ifc.evt_id), 32'd0);
      step(2);
      chk("mrst_valid2", 32'(ifc.evt_valid), 32'd0);
      chk("mrst_ovf", 32'(overflow), 32'd0);
      mon_q.delete();
      ifc.evt_ready = 1'b1;
      reset = 1'b0;
      step(1);
      chk("post_rst_k", 32'(ifc.evt_valid), 32'd0);
      step(1);
      chk("post_rst_valid", 32'(ifc.evt_valid), 32'd1);
      chk("post_rst_id", 32'(ifc.evt_id), 32'd1);
      chk("post_rst_type", 32'(ifc.evt_type), 32'd0);
      btn_db = 4'b0000;
      step(6);
      chk("post_rst_count", 32'(mon_q.size()), 32'd2);
      chk_evt(0, 3'd1, 2'b00, "post_rst_p");
      chk_evt(1, 3'd1, 2'b01, "post_rst_r");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
